conv_unit: RTL and testbench
============================

Name: conv_unit

Overview:
- Streaming 1-D convolution stage; consumes the 64-bit sample stream and 4-tap kernel produced by the test data generator.
- Holds a sliding window of the last LEN accepted samples.
- Computes the unsigned dot product of the window with the kernel using a bit-serial shift-add multiplier.
- Returns the result over a valid/ready handshake to the checker/output stage.

Parameters:
WIDTH, 64, bits per sample and per kernel tap
LEN, 4, number of taps / window depth (power of two, >=2)
RES_W, 2*WIDTH+$clog2(LEN), result width (130 at defaults); derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream sample valid
in_ready  output  1  conv_unit can accept a sample
in_data  input  WIDTH  sample
kernel  input  Conv::data_vector  LEN taps, kernel.data[0..LEN-1], each WIDTH bits
result_valid  output  1  result available
result_ready  input  1  downstream accepts result
result_data  output  RES_W  convolution result

Behaviour:
- Reset (rst high at a clock edge): state IDLE; window[0..LEN-1]=0; kernel latch=0; accumulator=0; counters=0; in_ready=1 after reset; result_valid=0; result_data=0.
- Reset mid-operation aborts any computation or pending result with no output.
- Arithmetic: all unsigned. result = sum over i of window[i]*kernel.data[i], where window[0] is the newest sample. Full precision to RES_W; no truncation or overflow.
- Accept: in_valid & in_ready at an edge performs these updates:
  - window shifts: window[i] <= window[i-1] for i>=1; window[0] <= in_data.
  - all kernel taps latched.
  - accumulator cleared.
  - state -> MUL.
- Kernel changes after the accepting edge do not affect that result.
- Unfilled window slots are zero. The first LEN-1 results are partial sums.
- FSM:
  - IDLE: in_ready=1, result_valid=0.
  - MUL: in_ready=0. Tap counter t in 0..LEN-1; bit counter b in 0..WIDTH-1. Each cycle, if latched kernel.data[t] bit b is 1, accumulator += window[t] << b. b increments; on b=WIDTH-1, b wraps to 0 and t increments. After the cycle with t=LEN-1, b=WIDTH-1, state -> DONE. MUL lasts exactly LEN*WIDTH cycles (256).
  - DONE: result_valid=1; result_data=accumulator, held stable. On result_valid & result_ready, state -> IDLE. Samples are never accepted in DONE (in_ready=0).
- Latency: result_valid is high from the edge LEN*WIDTH cycles after the accepting edge.
- Back-to-back: earliest next accept is the cycle after the result handshake, so throughput is 1 result per LEN*WIDTH+2 cycles.
- in_valid while busy is ignored (no accept); upstream holds data per the valid/ready rule.
- result_ready may be held high indefinitely.

Optional Feature:
- CONV_FAST_MUL_EN defined:
  - MUL uses one full combinational WIDTH x WIDTH multiply per tap per cycle.
  - MUL lasts LEN cycles (t counter only); result_valid is high LEN cycles after the accepting edge.
  - Results are bit-identical to the serial mode.
- Not defined: bit-serial mode as above.
- The ports are identical in both modes.

Decomposition:
- Package Conv holds:
  - WIDTH, LEN, and RES_W constants.
  - typedef data_vector (struct with data[LEN] of WIDTH bits), shared with the generator.
  - typedef result_t (RES_W bits).
  - the state enum {IDLE, MUL, DONE}.
- One natural sub-module: conv_mac_step, the per-cycle shift-add accumulate. In serial mode it takes accumulator, operand, multiplier bit, and shift; in fast mode it becomes the full product-add.

Test Plan:
- Kernel {1,2,3,4}, single sample 5 after reset -> result_data=5, result_valid exactly 256 cycles after accept, in_ready=0 throughout.
- Same kernel, samples 5,6,7,8 back-to-back with result_ready=1 -> results 5, 16, 34, 60 in order.
- All kernel taps and 4 samples = 0xFFFF_FFFF_FFFF_FFFF -> fourth result = 2^130 - 2^67 + 4 (full 130 bits checked).
- result_ready held low 10 cycles in DONE -> result_valid stays 1, result_data stable, in_ready=0, in_valid ignored. Handshake then returns to IDLE next cycle.
- rst asserted 100 cycles into MUL -> next cycle result_valid=0, in_ready=1. Then kernel {1,0,0,0} with sample 3 -> result 3 (window cleared).
- Kernel changed to {0,0,0,0} one cycle after accepting 9 with kernel {2,...} -> result 18. Repeat with CONV_FAST_MUL_EN defined -> same value at 4-cycle latency.

Source files
------------

// File: rtl/Conv.sv
// Shared constants and types for the conv_unit convolution stage and the data generator.
package Conv;

  localparam int WIDTH = 64;
  localparam int LEN   = 4;
  localparam int RES_W = 2*WIDTH + $clog2(LEN);
  localparam int T_W   = $clog2(LEN);
  localparam int B_W   = $clog2(WIDTH);

  typedef struct packed {
    logic [LEN-1:0][WIDTH-1:0] data;
  } data_vector;

  typedef logic [RES_W-1:0] result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/conv_mac_step.sv
// One multiply-accumulate step: a single shift-add (serial) or a full tap product (CONV_FAST_MUL_EN).
module conv_mac_step import Conv::*; (
  input  result_t            acc,
  input  logic [WIDTH-1:0]   operand,
`ifdef CONV_FAST_MUL_EN
  input  logic [WIDTH-1:0]   multiplier,
`else
  input  logic               mul_bit,
  input  logic [B_W-1:0]     shift,
`endif
  output result_t            acc_next
);

`ifdef CONV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_s;

  assign prod_s   = (2*WIDTH)'(operand) * (2*WIDTH)'(multiplier);
  assign acc_next = acc + result_t'(prod_s);
`else
  // Add the shifted operand only when the current multiplier bit is set.
  always_comb begin
    if (mul_bit) begin
      acc_next = acc + (result_t'(operand) << shift);
    end else begin
      acc_next = acc;
    end
  end
`endif

endmodule

// File: rtl/conv_unit.sv
// Streaming 4-tap unsigned convolution with valid/ready in and out.
// Bit-serial multiply by default; CONV_FAST_MUL_EN selects one full tap product per cycle.
module conv_unit import Conv::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  data_vector        kernel,
  output logic              result_valid,
  input  logic              result_ready,
  output result_t           result_data
);

  localparam logic [T_W-1:0] T_LAST = T_W'(LEN-1);
  localparam logic [T_W-1:0] T_ONE  = {{(T_W-1){1'b0}}, 1'b1};
`ifndef CONV_FAST_MUL_EN
  localparam logic [B_W-1:0] B_LAST = B_W'(WIDTH-1);
  localparam logic [B_W-1:0] B_ONE  = {{(B_W-1){1'b0}}, 1'b1};
`endif

  state_e                     state_r, state_next_s;
  logic [LEN-1:0][WIDTH-1:0]  win_r;
  data_vector                 kern_r;
  result_t                    acc_r, acc_next_s, mac_acc_s;
  logic [T_W-1:0]             t_r, t_next_s;
  logic                       in_ready_r, result_valid_r;
  logic                       accept_s;
  logic [WIDTH-1:0]           tap_s;
`ifndef CONV_FAST_MUL_EN
  logic [B_W-1:0]             b_r, b_next_s;
`endif

  assign accept_s     = in_valid & in_ready_r;
  assign tap_s        = kern_r.data[t_r];
  assign in_ready     = in_ready_r;
  assign result_valid = result_valid_r;
  assign result_data  = acc_r;

  conv_mac_step u_mac (
    .acc        (acc_r),
    .operand    (win_r[t_r]),
`ifdef CONV_FAST_MUL_EN
    .multiplier (tap_s),
`else
    .mul_bit    (tap_s[b_r]),
    .shift      (b_r),
`endif
    .acc_next   (mac_acc_s)
  );

  // Next-state, accumulator and tap/bit counter sequencing.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    t_next_s     = t_r;
`ifndef CONV_FAST_MUL_EN
    b_next_s     = b_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = MUL;
          acc_next_s   = '0;
          t_next_s     = '0;
`ifndef CONV_FAST_MUL_EN
          b_next_s     = '0;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        acc_next_s = mac_acc_s;
`ifdef CONV_FAST_MUL_EN
        if (t_r == T_LAST) begin
          state_next_s = DONE;
          t_next_s     = '0;
        end else begin
          t_next_s = t_r + T_ONE;
        end
`else
        if (b_r == B_LAST) begin
          b_next_s = '0;
          if (t_r == T_LAST) begin
            state_next_s = DONE;
            t_next_s     = '0;
          end else begin
            t_next_s = t_r + T_ONE;
          end
        end else begin
          b_next_s = b_r + B_ONE;
        end
`endif
      end
      DONE: begin
        if (result_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      win_r          <= '0;
      kern_r         <= '0;
      acc_r          <= '0;
      t_r            <= '0;
`ifndef CONV_FAST_MUL_EN
      b_r            <= '0;
`endif
      in_ready_r     <= 1'b1;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      acc_r          <= acc_next_s;
      t_r            <= t_next_s;
`ifndef CONV_FAST_MUL_EN
      b_r            <= b_next_s;
`endif
      in_ready_r     <= (state_next_s == IDLE);
      result_valid_r <= (state_next_s == DONE);
      if (accept_s) begin
        win_r  <= {win_r[LEN-2:0], in_data};
        kern_r <= kernel;
      end else begin
        win_r  <= win_r;
        kern_r <= kern_r;
      end
    end
  end

endmodule

// File: tb/tb_conv_unit.sv
// Self-checking bench for conv_unit: cycle-level reference model plus directed scenarios.
module tb_conv_unit;
  import Conv::*;

`ifdef CONV_FAST_MUL_EN
  localparam int LAT = LEN;
`else
  localparam int LAT = LEN*WIDTH;
`endif
  localparam int PERIOD = LAT + 2;
  localparam int MID    = (LAT > 100) ? 100 : LAT/2;
  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  data_vector       kernel;
  logic             result_valid;
  logic             result_ready;
  result_t          result_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  conv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .kernel       (kernel),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  task automatic chk(input string name, input result_t act, input result_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: window array, result computed as a plain dot product at accept time,
  // then a countdown of LAT cycles before the result is offered.
  logic [WIDTH-1:0] m_win [LEN];
  result_t          m_res;
  int               m_phase = P_IDLE;
  int               m_cnt   = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < LEN; i++) m_win[i] = '0;
      m_res   = '0;
      m_phase = P_IDLE;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (in_valid) begin
            for (int i = LEN-1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = in_data;
            m_res = '0;
            for (int i = 0; i < LEN; i++)
              m_res = m_res + result_t'(m_win[i]) * result_t'(kernel.data[i]);
            m_cnt   = 0;
            m_phase = P_BUSY;
          end
        end
        P_BUSY: begin
          m_cnt++;
          if (m_cnt == LAT) m_phase = P_DONE;
        end
        default: begin
          if (result_ready) m_phase = P_IDLE;
        end
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", result_t'(in_ready), result_t'(m_phase == P_IDLE));
      chk("model_result_valid", result_t'(result_valid), result_t'(m_phase == P_DONE));
      if (m_phase == P_DONE) chk("model_result_data", result_data, m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_kernel(input logic [WIDTH-1:0] k0, k1, k2, k3);
    kernel.data[0] = k0;
    kernel.data[1] = k1;
    kernel.data[2] = k2;
    kernel.data[3] = k3;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 2*PERIOD) begin
      tick();
      n++;
    end
    chk("accept_wait", result_t'(in_ready), 1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_valid(output int v_cyc);
    int n = 0;
    while (!result_valid && n < 2*PERIOD) begin
      tick();
      n++;
    end
    chk("valid_wait", result_t'(result_valid), 1);
    v_cyc = cyc;
  endtask

  initial begin
    int a, v, prev_a;
    int exp_seq [4];
    result_t big;
    logic [WIDTH-1:0] ones;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; result_ready = 1'b0; kernel = '0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_in_ready", result_t'(in_ready), 1);
    chk("rst_result_valid", result_t'(result_valid), 0);
    chk("rst_result_data", result_data, 0);

    // Single sample, latency, then a stalled DONE.
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    send(64'd5, a);
    wait_valid(v);
    chk("single_latency", result_t'(v - a), result_t'(LAT));
    chk("single_data", result_data, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 64'd99;
      tick();
      chk("stall_valid", result_t'(result_valid), 1);
      chk("stall_data", result_data, 5);
      chk("stall_in_ready", result_t'(in_ready), 0);
    end
    in_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("hs_in_ready", result_t'(in_ready), 1);
    chk("hs_result_valid", result_t'(result_valid), 0);

    // Back-to-back stream with downstream always ready.
    do_reset();
    result_ready = 1'b1;
    exp_seq = '{5, 16, 34, 60};
    prev_a = 0;
    for (int i = 0; i < 4; i++) begin
      send(WIDTH'(5 + i), a);
      if (i > 0) chk("b2b_period", result_t'(a - prev_a), result_t'(PERIOD));
      prev_a = a;
      wait_valid(v);
      chk("b2b_latency", result_t'(v - a), result_t'(LAT));
      chk("b2b_data", result_data, result_t'(exp_seq[i]));
    end
    tick();

    // All-ones taps and samples: full-width result.
    do_reset();
    ones = '1;
    set_kernel(ones, ones, ones, ones);
    for (int i = 0; i < 4; i++) begin
      send(ones, a);
      wait_valid(v);
    end
    big = '1;
    big = big << 67;
    big = big + 130'd4;
    chk("max_data", result_data, big);
    tick();

    // Reset in the middle of a multiply.
    do_reset();
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    send(64'd7, a);
    repeat (MID) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_result_valid", result_t'(result_valid), 0);
    chk("midrst_in_ready", result_t'(in_ready), 1);
    set_kernel(64'd1, 64'd0, 64'd0, 64'd0);
    send(64'd3, a);
    wait_valid(v);
    chk("midrst_data", result_data, 3);
    tick();

    // Kernel changed right after the accept must not matter.
    do_reset();
    set_kernel(64'd2, 64'd3, 64'd4, 64'd5);
    send(64'd9, a);
    kernel = '0;
    wait_valid(v);
    chk("kchg_latency", result_t'(v - a), result_t'(LAT));
    chk("kchg_data", result_data, 18);
    tick();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
